// File: rtl/inject_pkg.sv
// Shared definitions for the inject scheduler: FSM encoding, counter width
// and the saturating increment used by the optional injection counter.
package inject_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_READY = 2'd1,
        WAIT_DONE  = 2'd2,
        RELEASE    = 2'd3
    } state_e;

    localparam int INJECT_COUNT_W = 16;

    function automatic logic [INJECT_COUNT_W-1:0] sat_inc(input logic [INJECT_COUNT_W-1:0] v);
        return (&v) ? v : v + INJECT_COUNT_W'(1);
    endfunction

endpackage

// File: rtl/payload_regfile.sv
// Payload word storage: synchronous write, asynchronous read, no reset needed.
module payload_regfile #(
    parameter int NUM_DATA_BITS = 8,
    parameter int PAYLOAD_DEPTH = 4,
    parameter int ADDR_W        = $clog2(PAYLOAD_DEPTH)
) (
    input  logic                     clk,
    input  logic                     wr_en_i,
    input  logic [ADDR_W-1:0]        wr_addr_i,
    input  logic [NUM_DATA_BITS-1:0] wr_data_i,
    input  logic [ADDR_W-1:0]        rd_addr_i,
    output logic [NUM_DATA_BITS-1:0] rd_data_o
);

    logic [NUM_DATA_BITS-1:0] mem_q [PAYLOAD_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/inject_scheduler.sv
// Watches received bus words for a trigger and then injects a stored payload
// through the fake transmitter. Define INJECT_COUNTER_EN to add inject_count.
module inject_scheduler
    import inject_pkg::*;
#(
    parameter int NUM_DATA_BITS = 8,
    parameter int PAYLOAD_DEPTH = 4
) (
    input  logic                             sys_clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic [NUM_DATA_BITS-1:0]         trig_value,
    input  logic [$clog2(PAYLOAD_DEPTH):0]   payload_len,
    input  logic                             payload_wr_en,
    input  logic [$clog2(PAYLOAD_DEPTH)-1:0] payload_wr_addr,
    input  logic [NUM_DATA_BITS-1:0]         payload_wr_data,
    input  logic                             recv_new_data,
    input  logic [NUM_DATA_BITS-1:0]         recv_data,
    input  logic                             send_ready,
    input  logic                             send_done,
    output logic                             fake_select,
    output logic                             send_start,
    output logic [NUM_DATA_BITS-1:0]         send_data,
    output logic                             keep_alive,
    output logic                             busy
`ifdef INJECT_COUNTER_EN
    ,
    output logic [INJECT_COUNT_W-1:0]        inject_count
`endif
);

    localparam int ADDR_W = $clog2(PAYLOAD_DEPTH);
    localparam int LEN_W  = ADDR_W + 1;
    localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(PAYLOAD_DEPTH);

    state_e                   state_q, state_d;
    logic [ADDR_W-1:0]        idx_q, idx_d;
    logic [LEN_W-1:0]         eff_len_q, eff_len_d;
    logic                     send_start_q, send_start_d;
    logic [NUM_DATA_BITS-1:0] send_data_q, send_data_d;
    logic [NUM_DATA_BITS-1:0] rd_data;
    logic                     busy_w;
    logic                     trig_hit;
    logic                     last_word;
    logic                     more_words;

    assign busy_w     = (state_q != IDLE);
    assign trig_hit   = enable && recv_new_data && (recv_data == trig_value) && (payload_len != '0);
    assign last_word  = ({1'b0, idx_q} == (eff_len_q - LEN_W'(1)));
    assign more_words = ({1'b0, idx_q} <  (eff_len_q - LEN_W'(1)));

    // Writes are gated while busy so a running sequence sees a frozen payload;
    // a write on the trigger cycle still lands because the FSM is still IDLE.
    payload_regfile #(
        .NUM_DATA_BITS (NUM_DATA_BITS),
        .PAYLOAD_DEPTH (PAYLOAD_DEPTH),
        .ADDR_W        (ADDR_W)
    ) u_payload (
        .clk       (sys_clk),
        .wr_en_i   (payload_wr_en && !busy_w),
        .wr_addr_i (payload_wr_addr),
        .wr_data_i (payload_wr_data),
        .rd_addr_i (idx_q),
        .rd_data_o (rd_data)
    );

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            eff_len_q    <= '0;
            send_start_q <= 1'b0;
            send_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            eff_len_q    <= eff_len_d;
            send_start_q <= send_start_d;
            send_data_q  <= send_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        eff_len_d    = eff_len_q;
        send_start_d = 1'b0;
        send_data_d  = send_data_q;
        case (state_q)
            IDLE: begin
                if (trig_hit) begin
                    state_d   = WAIT_READY;
                    idx_d     = '0;
                    eff_len_d = (payload_len > DEPTH_LEN) ? DEPTH_LEN : payload_len;
                end
            end
            WAIT_READY: begin
                // send_data is registered with the start pulse and held until the next word.
                if (send_ready) begin
                    send_start_d = 1'b1;
                    send_data_d  = rd_data;
                    state_d      = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (send_done) begin
                    if (last_word) begin
                        state_d = RELEASE;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = WAIT_READY;
                    end
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign fake_select = busy_w;
    assign busy        = busy_w;
    assign keep_alive  = ((state_q == WAIT_READY) || (state_q == WAIT_DONE)) && more_words;
    assign send_start  = send_start_q;
    assign send_data   = send_data_q;

`ifdef INJECT_COUNTER_EN
    logic [INJECT_COUNT_W-1:0] inject_count_q;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            inject_count_q <= '0;
        end else if (state_q == RELEASE) begin
            inject_count_q <= sat_inc(inject_count_q);
        end
    end

    assign inject_count = inject_count_q;
`endif

endmodule
